// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus for the register file and busy scoreboard.
// master = decode + writeback side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              busy_a;
    logic              busy_b;
    logic              stall;

    modport master (
        output ra, rb, reg_write, rd, wdata, issue_valid, issue_rd,
        input  a, b, busy_a, busy_b, stall
    );

    modport slave (
        input  ra, rb, reg_write, rd, wdata, issue_valid, issue_rd,
        output a, b, busy_a, busy_b, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with hardwired zero/constant registers,
// optional writeback-to-read bypass and a per-register busy scoreboard
// that stalls issue on RAW and WAW hazards.

// One read port: hardwired decode, bypass mux and RAW busy qualification.
module regfile_scoreboard_rdport #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 3,
    parameter bit                CONST_TOP = 1'b1,
    parameter logic [DATA_W-1:0] TOP_VAL   = 8'h7F,
    parameter bit                BYPASS    = 1'b1
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              busy_bit_i,
    input  logic              reg_write_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    logic byp;

    // Priority: zero reg, constant top reg, same-cycle writeback, storage.
    always_comb begin
        byp     = BYPASS && reg_write_i && (rd_i == raddr_i);
        rdata_o = stored_i;
        if (raddr_i == '0)
            rdata_o = '0;
        else if (CONST_TOP && raddr_i == TOP_ADDR)
            rdata_o = TOP_VAL;
        else if (byp)
            rdata_o = wdata_i;
        busy_o = busy_bit_i && !byp;
    end
endmodule

module regfile_scoreboard #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 3,
    parameter bit                CONST_TOP = 1'b1,
    parameter logic [DATA_W-1:0] TOP_VAL   = 8'h7F,
    parameter bit                BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int                NREG     = 1 << ADDR_W;
    localparam int                NPORT    = 2;
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    logic [NREG-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [NREG-1:0]              busy_q, busy_d;

    logic [NPORT-1:0][ADDR_W-1:0] raddr;
    logic [NPORT-1:0][DATA_W-1:0] rdata;
    logic [NPORT-1:0]             rbusy;

    logic wb_clr, iss_set, waw, stall;

    function automatic logic is_hw(input logic [ADDR_W-1:0] addr);
        return (addr == '0) || (CONST_TOP && addr == TOP_ADDR);
    endfunction

    assign raddr[0] = bus.ra;
    assign raddr[1] = bus.rb;

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        regfile_scoreboard_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CONST_TOP(CONST_TOP),
            .TOP_VAL(TOP_VAL), .BYPASS(BYPASS)
        ) u_rdport (
            .raddr_i     (raddr[p]),
            .stored_i    (mem_q[raddr[p]]),
            .busy_bit_i  (busy_q[raddr[p]]),
            .reg_write_i (bus.reg_write),
            .rd_i        (bus.rd),
            .wdata_i     (bus.wdata),
            .rdata_o     (rdata[p]),
            .busy_o      (rbusy[p])
        );
    end

    assign bus.a      = rdata[0];
    assign bus.b      = rdata[1];
    assign bus.busy_a = rbusy[0];
    assign bus.busy_b = rbusy[1];
    assign bus.stall  = stall;

    // Hazard detection and next-state for storage and scoreboard.
    // WAW is released by a same-cycle writeback even without bypass, since
    // the pending write retires at this edge and the new issue re-sets busy.
    always_comb begin
        wb_clr  = bus.reg_write && !is_hw(bus.rd);
        waw     = busy_q[bus.issue_rd] && !(bus.reg_write && bus.rd == bus.issue_rd);
        stall   = bus.issue_valid && (rbusy[0] || rbusy[1] || waw);
        iss_set = bus.issue_valid && !stall && !is_hw(bus.issue_rd);

        mem_d = mem_q;
        if (wb_clr)
            mem_d[bus.rd] = bus.wdata;

        // Set wins over clear when issue and writeback hit the same index.
        busy_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_d[i] = (busy_q[i] && !(wb_clr && bus.rd == ADDR_W'(i)))
                      || (iss_set && bus.issue_rd == ADDR_W'(i));
        end
    end

    // State registers; reset overrides any same-cycle write or issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end
endmodule
